// File: rtl/instruction_decode_pipe.sv
// Purpose: single-stage instruction decode with register read, writeback bypass and load-use interlock.
// Latency: one cycle from instruction_if to the *_id outputs; reg*_index_rf and stall_if are combinational.
// Backpressure: stall_ex freezes the output register and raises stall_if; a load-use hazard inserts one bubble.
//
// Ports:
//   clk, rst_n                        clock, synchronous active-low reset
//   valid_if, instruction_if          fetched instruction {opcode, rd, rs1, rs2}
//   next_program_counter_if           PC+1 of the fetched instruction
//   branch_prediction_bp              taken prediction from the branch predictor
//   reg1/2_index_rf, reg1/2_data_rf   register-file read ports
//   wb_we, wb_index, wb_data          same-cycle writeback, bypassed into the read data
//   stall_ex, flush_id                downstream hold / discard the decode stage
//   stall_if                          fetch must hold its current instruction
//   *_id                              registered decode results
module instruction_decode_pipe #(
   parameter int  DATA_W    = 16,
   parameter int  REG_IDX_W = 4,
   localparam int INSTR_W   = 4 + 3*REG_IDX_W
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 valid_if,
   input  logic [INSTR_W-1:0]   instruction_if,
   input  logic [DATA_W-1:0]    next_program_counter_if,
   input  logic                 branch_prediction_bp,
   output logic [REG_IDX_W-1:0] reg1_index_rf,
   output logic [REG_IDX_W-1:0] reg2_index_rf,
   input  logic [DATA_W-1:0]    reg1_data_rf,
   input  logic [DATA_W-1:0]    reg2_data_rf,
   input  logic                 wb_we,
   input  logic [REG_IDX_W-1:0] wb_index,
   input  logic [DATA_W-1:0]    wb_data,
   input  logic                 stall_ex,
   input  logic                 flush_id,
   output logic                 stall_if,
   output logic                 valid_id,
   output logic [3:0]           opcode_id,
   output logic [5:0]           control_id,
   output logic [DATA_W-1:0]    reg1_data_id,
   output logic [DATA_W-1:0]    reg2_data_id,
   output logic [DATA_W-1:0]    immediate_id,
   output logic [DATA_W-1:0]    target_address_id,
   output logic [DATA_W-1:0]    next_program_counter_id,
   output logic [REG_IDX_W-1:0] dest_reg_index_id,
   output logic                 branch_prediction_id,
   output logic                 illegal_id,
   output logic [15:0]          hazard_count_id
);

   localparam int R = REG_IDX_W;

   localparam logic [3:0] OP_ADDI  = 4'h8;
   localparam logic [3:0] OP_LOAD  = 4'h9;
   localparam logic [3:0] OP_STORE = 4'hA;
   localparam logic [3:0] OP_BEQ   = 4'hB;
   localparam logic [3:0] OP_JUMP  = 4'hC;

   // control layout: {reg_write, mem_read, mem_write, branch, jump, alu_src_imm}
   localparam int CTRL_MEM_READ = 4;

   typedef struct packed {
      logic              vld;
      logic [3:0]        opc;
      logic [5:0]        ctrl;
      logic [DATA_W-1:0] r1;
      logic [DATA_W-1:0] r2;
      logic [DATA_W-1:0] imm;
      logic [DATA_W-1:0] tgt;
      logic [DATA_W-1:0] npc;
      logic [R-1:0]      dest;
      logic              bp;
      logic              ill;
   } dec_t;

   dec_t        dec;
   dec_t        q;
   logic [15:0] hcnt;

   logic [3:0]  opc;
   logic [R-1:0] rd, rs1, rs2;
   logic is_alu, is_addi, is_load, is_store, is_beq, is_jump, is_illegal;
   logic reads1, reads2, writes;
   logic [DATA_W-1:0] r1_val, r2_val, imm_short, imm_long;
   logic hazard;

   assign opc = instruction_if[INSTR_W-1 -: 4];
   assign rd  = instruction_if[3*R-1 -: R];
   assign rs1 = instruction_if[2*R-1 -: R];
   assign rs2 = instruction_if[R-1:0];

   assign is_alu     = (opc >= 4'h1) && (opc <= 4'h7);
   assign is_addi    = (opc == OP_ADDI);
   assign is_load    = (opc == OP_LOAD);
   assign is_store   = (opc == OP_STORE);
   assign is_beq     = (opc == OP_BEQ);
   assign is_jump    = (opc == OP_JUMP);
   assign is_illegal = (opc >= 4'hD);

   // STORE and BEQ carry their second source in the rd field.
   assign reads1 = is_alu | is_addi | is_load | is_store | is_beq;
   assign reads2 = is_alu | is_store | is_beq;
   assign writes = is_alu | is_addi | is_load;

   assign reg1_index_rf = rs1;
   assign reg2_index_rf = (is_store | is_beq) ? rd : rs2;

   // Register 0 reads as zero and is never bypassed.
   assign r1_val = (reg1_index_rf == '0) ? '0 :
                   (wb_we && (wb_index == reg1_index_rf)) ? wb_data : reg1_data_rf;
   assign r2_val = (reg2_index_rf == '0) ? '0 :
                   (wb_we && (wb_index == reg2_index_rf)) ? wb_data : reg2_data_rf;

   // Sign extension assumes DATA_W is wider than the 3-field jump offset.
   assign imm_short = {{(DATA_W-R){rs2[R-1]}}, rs2};
   assign imm_long  = {{(DATA_W-3*R){instruction_if[3*R-1]}}, instruction_if[3*R-1:0]};

   always_comb begin
      dec = '0;
      if (valid_if) begin
         dec.vld  = 1'b1;
         dec.opc  = opc;
         dec.r1   = r1_val;
         dec.r2   = r2_val;
         dec.npc  = next_program_counter_if;
         dec.bp   = branch_prediction_bp;
         dec.ill  = is_illegal;
         // Only register-writing opcodes name a destination; rd=0 stays 0.
         if (writes) begin
            dec.dest = rd;
         end
         if (is_addi | is_load | is_store | is_beq) begin
            dec.imm = imm_short;
         end else if (is_jump) begin
            dec.imm = imm_long;
         end
         if (is_beq | is_jump) begin
            dec.tgt = next_program_counter_if + dec.imm;
         end
         dec.ctrl = {writes && (rd != '0), is_load, is_store, is_beq, is_jump,
                     is_addi | is_load | is_store};
      end
   end

   // Load-use: the LOAD currently in the output register targets a source
   // the incoming instruction actually reads.
   assign hazard = valid_if && q.vld && q.ctrl[CTRL_MEM_READ] && (q.dest != '0) &&
                   ((reads1 && (rs1 == q.dest)) || (reads2 && (reg2_index_rf == q.dest)));

   always_comb begin
      stall_if = 1'b0;
      if (rst_n && !flush_id) begin
         stall_if = stall_ex | hazard;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q    <= '0;
         hcnt <= '0;
      end else if (flush_id) begin
         q <= '0;
      end else if (stall_ex) begin
         q <= q;
      end else if (hazard) begin
         q <= '0;
         if (hcnt != 16'hFFFF) begin
            hcnt <= hcnt + 16'd1;
         end
      end else begin
         q <= dec;
      end
   end

   assign valid_id                = q.vld;
   assign opcode_id               = q.opc;
   assign control_id              = q.ctrl;
   assign reg1_data_id            = q.r1;
   assign reg2_data_id            = q.r2;
   assign immediate_id            = q.imm;
   assign target_address_id       = q.tgt;
   assign next_program_counter_id = q.npc;
   assign dest_reg_index_id       = q.dest;
   assign branch_prediction_id    = q.bp;
   assign illegal_id              = q.ill;
   assign hazard_count_id         = hcnt;

endmodule
